// File: rtl/xsram_arbiter_pkg.sv
// Shared encodings for the X data SRAM arbiter: slot owners, read-return tags
// and the default host starvation limit.
package xsram_arbiter_pkg;

    localparam int STARVE_MAX_DEF = 8;
    localparam int CNT_W          = 8;

    typedef enum logic [2:0] {
        OWN_NONE,
        OWN_HOSTF,
        OWN_WBUF,
        OWN_SEQ,
        OWN_WR,
        OWN_HOST
    } owner_t;

    typedef enum logic [1:0] {
        TAG_NONE,
        TAG_SEQ,
        TAG_HOST
    } tag_t;

    function automatic logic owner_is_host(input owner_t own);
        return (own == OWN_HOSTF) || (own == OWN_HOST);
    endfunction

endpackage

// File: rtl/xsram_arbiter_if.sv
// Requester-side and SRAM-side signals of the X SRAM arbiter; slave is the
// arbiter's view, master is the view of whatever surrounds it.
interface xsram_arbiter_if #(
    parameter int AW = 16,
    parameter int DW = 128
);
    logic          PURGE;
    logic          RCEBX;
    logic [AW-1:0] RADDRX;
    logic          WCEBX;
    logic [AW-1:0] WADDRX;
    logic [DW-1:0] WDATAX;
    logic          X_STALL;
    logic          SEQ_RVALID;
    logic [DW-1:0] SEQ_RDATA;
    logic          HOST_REQ;
    logic          HOST_WE;
    logic [AW-1:0] HOST_ADDR;
    logic [DW-1:0] HOST_WDATA;
    logic          HOST_GNT;
    logic          HOST_RVALID;
    logic [DW-1:0] HOST_RDATA;
    logic          CEB;
    logic          WEB;
    logic [AW-1:0] A;
    logic [DW-1:0] D;
    logic [DW-1:0] Q;

    modport slave (
        input  PURGE, RCEBX, RADDRX, WCEBX, WADDRX, WDATAX,
        input  HOST_REQ, HOST_WE, HOST_ADDR, HOST_WDATA, Q,
        output X_STALL, SEQ_RVALID, SEQ_RDATA, HOST_GNT, HOST_RVALID, HOST_RDATA,
        output CEB, WEB, A, D
    );

    modport master (
        output PURGE, RCEBX, RADDRX, WCEBX, WADDRX, WDATAX,
        output HOST_REQ, HOST_WE, HOST_ADDR, HOST_WDATA, Q,
        input  X_STALL, SEQ_RVALID, SEQ_RDATA, HOST_GNT, HOST_RVALID, HOST_RDATA,
        input  CEB, WEB, A, D
    );
endinterface

// File: rtl/xsram_starve_ctr.sv
// Counts cycles the host is kept waiting and raises host_force once the wait
// reaches STARVE_MAX, so the host wins the slot on the following cycle.
module xsram_starve_ctr
    import xsram_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic CLK,
    input  logic RST,
    input  logic purge,
    input  logic host_req,
    input  logic host_gnt,
    output logic host_force
);

    localparam logic [CNT_W-1:0] MAX_C = STARVE_MAX[CNT_W-1:0];

    logic [CNT_W-1:0] starve_cnt;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            starve_cnt <= '0;
            host_force <= 1'b0;
        end else if (purge || host_gnt) begin
            starve_cnt <= '0;
            host_force <= 1'b0;
        end else begin
            if (host_req && (starve_cnt != MAX_C))
                starve_cnt <= starve_cnt + 1'b1;
            host_force <= (starve_cnt == MAX_C);
        end
    end

endmodule

// File: rtl/xsram_arbiter.sv
// Single-port X SRAM arbiter: sequencer reads, write-back through a one-entry
// holding buffer, and a host port protected from starvation.
module xsram_arbiter
    import xsram_arbiter_pkg::*;
#(
    parameter int AW         = 16,
    parameter int DW         = 128,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic            CLK,
    input  logic            RST,
    xsram_arbiter_if.slave  bus
);

    owner_t        owner;
    logic          host_force;
    logic          host_gnt;
    logic          x_stall;
    logic          wr_capture;
    logic          wbuf_valid;
    logic [AW-1:0] wbuf_addr;
    logic [DW-1:0] wbuf_data;
    tag_t          rd_tag_p1;

    // Reset forces the slot idle so the SRAM is never enabled while RST is high.
    always_comb begin
        owner = OWN_NONE;
        if (RST)                owner = OWN_NONE;
        else if (host_force)    owner = OWN_HOSTF;
        else if (wbuf_valid)    owner = OWN_WBUF;
        else if (!bus.RCEBX)    owner = OWN_SEQ;
        else if (!bus.WCEBX)    owner = OWN_WR;
        else if (bus.HOST_REQ)  owner = OWN_HOST;
    end

    assign x_stall  = (wbuf_valid & ~bus.RCEBX)
                    | (host_force & (~bus.RCEBX | ~bus.WCEBX));
    assign host_gnt = owner_is_host(owner);

    // A write not issuing directly is parked whenever the slot went to the
    // sequencer read or to the previously buffered write.
    assign wr_capture = ~bus.WCEBX & ~x_stall
                      & ((owner == OWN_SEQ) || (owner == OWN_WBUF));

    always_comb begin
        bus.A   = bus.RADDRX;
        bus.D   = bus.WDATAX;
        bus.WEB = 1'b1;
        bus.CEB = (owner == OWN_NONE);
        case (owner)
            OWN_HOSTF, OWN_HOST: begin
                bus.A   = bus.HOST_ADDR;
                bus.D   = bus.HOST_WDATA;
                bus.WEB = ~bus.HOST_WE;
            end
            OWN_WBUF: begin
                bus.A   = wbuf_addr;
                bus.D   = wbuf_data;
                bus.WEB = 1'b0;
            end
            OWN_SEQ: begin
                bus.A   = bus.RADDRX;
            end
            OWN_WR: begin
                bus.A   = bus.WADDRX;
                bus.D   = bus.WDATAX;
                bus.WEB = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            wbuf_valid <= 1'b0;
        else if (wr_capture)
            wbuf_valid <= 1'b1;
        else if (owner == OWN_WBUF)
            wbuf_valid <= 1'b0;
    end

    always_ff @(posedge CLK) begin
        if (wr_capture) begin
            wbuf_addr <= bus.WADDRX;
            wbuf_data <= bus.WDATAX;
        end
    end

    // Stage p1: read-return tag, aligned with Q one cycle after the access.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            rd_tag_p1 <= TAG_NONE;
        else if (owner == OWN_SEQ)
            rd_tag_p1 <= TAG_SEQ;
        else if (owner_is_host(owner) && !bus.HOST_WE)
            rd_tag_p1 <= TAG_HOST;
        else
            rd_tag_p1 <= TAG_NONE;
    end

    assign bus.X_STALL     = x_stall;
    assign bus.HOST_GNT    = host_gnt;
    assign bus.SEQ_RVALID  = (rd_tag_p1 == TAG_SEQ);
    assign bus.HOST_RVALID = (rd_tag_p1 == TAG_HOST);
    assign bus.SEQ_RDATA   = bus.Q;
    assign bus.HOST_RDATA  = bus.Q;

    xsram_starve_ctr #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve (
        .CLK        (CLK),
        .RST        (RST),
        .purge      (bus.PURGE),
        .host_req   (bus.HOST_REQ),
        .host_gnt   (host_gnt),
        .host_force (host_force)
    );

endmodule

// File: tb/tb_xsram_arbiter.sv
// Bench for xsram_arbiter: directed scenarios followed by randomized traffic
// against an acceptance-ordered memory model, with an SRAM macro model on the bus.
module tb_xsram_arbiter;

    localparam int AW = 16;
    localparam int DW = 128;
    localparam int STARVE_MAX = 8;

    logic CLK = 1'b0;
    logic RST;
    int   total = 0;
    int   bad   = 0;

    logic [DW-1:0] mem     [256];
    logic [DW-1:0] ref_mem [256];

    xsram_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    xsram_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(STARVE_MAX)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    // SRAM macro: Q valid one cycle after a read access
    always @(posedge CLK) begin
        if (!bus.CEB) begin
            if (!bus.WEB) mem[bus.A[7:0]] <= bus.D;
            else          bus.Q <= mem[bus.A[7:0]];
        end
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0b want %0b", tag, obs, exp);
        end
    endtask

    task automatic chka(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic chkd(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic edge1();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        bus.RCEBX    = 1'b1;
        bus.WCEBX    = 1'b1;
        bus.HOST_REQ = 1'b0;
        bus.PURGE    = 1'b0;
    endtask

    logic [DW-1:0] pval;
    logic [DW-1:0] old20;
    logic          rd_p, wr_p, h_p, h_we, h_purged;
    logic [AW-1:0] rd_a, wr_a, h_a;
    logic [DW-1:0] wr_d, h_d;
    int            h_wait;
    logic          e_sv, e_hv, stall, gnt;
    logic [DW-1:0] e_sd, e_hd;

    initial begin
        RST = 1'b1;
        idle();
        bus.RADDRX = '0; bus.WADDRX = '0; bus.WDATAX = '0;
        bus.HOST_WE = 1'b0; bus.HOST_ADDR = '0; bus.HOST_WDATA = '0;
        bus.RCEBX = 1'b0;
        bus.HOST_REQ = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        chk1("rst_ceb", bus.CEB, 1'b1);
        chk1("rst_web", bus.WEB, 1'b1);
        chk1("rst_stall", bus.X_STALL, 1'b0);
        chk1("rst_seq_rvalid", bus.SEQ_RVALID, 1'b0);
        chk1("rst_host_rvalid", bus.HOST_RVALID, 1'b0);
        chk1("rst_host_gnt", bus.HOST_GNT, 1'b0);
        idle();
        RST = 1'b0;

        // Preload through host writes on an idle bus
        for (int a = 0; a < 256; a++) begin
            edge1();
            bus.HOST_REQ   = 1'b1;
            bus.HOST_WE    = 1'b1;
            bus.HOST_ADDR  = 16'(a);
            bus.HOST_WDATA = (a == 16) ? {16{8'hAA}} : rnd128();
            ref_mem[a]     = bus.HOST_WDATA;
            #3;
            chk1("pre_gnt", bus.HOST_GNT, 1'b1);
        end
        edge1();
        idle();

        // Lone sequencer read
        edge1();
        bus.RCEBX = 1'b0; bus.RADDRX = 16'h0010;
        #3;
        chk1("lone_ceb", bus.CEB, 1'b0);
        chk1("lone_web", bus.WEB, 1'b1);
        chka("lone_a", bus.A, 16'h0010);
        chk1("lone_stall", bus.X_STALL, 1'b0);
        edge1();
        idle();
        chk1("lone_rvalid", bus.SEQ_RVALID, 1'b1);
        chkd("lone_rdata", bus.SEQ_RDATA, {16{8'hAA}});
        chk1("lone_host_rvalid", bus.HOST_RVALID, 1'b0);

        // Read/write collision on the same address
        edge1();
        old20 = ref_mem[8'h20];
        bus.RCEBX = 1'b0; bus.RADDRX = 16'h0020;
        bus.WCEBX = 1'b0; bus.WADDRX = 16'h0020; bus.WDATAX = {16{8'h55}};
        #3;
        chk1("col_stall", bus.X_STALL, 1'b0);
        chk1("col_web_t", bus.WEB, 1'b1);
        chka("col_a_t", bus.A, 16'h0020);
        edge1();
        idle();
        chk1("col_rvalid", bus.SEQ_RVALID, 1'b1);
        chkd("col_old_data", bus.SEQ_RDATA, old20);
        #3;
        chk1("col_ceb_t1", bus.CEB, 1'b0);
        chk1("col_web_t1", bus.WEB, 1'b0);
        chka("col_a_t1", bus.A, 16'h0020);
        chkd("col_d_t1", bus.D, {16{8'h55}});
        ref_mem[8'h20] = {16{8'h55}};
        edge1();
        bus.RCEBX = 1'b0; bus.RADDRX = 16'h0020;
        edge1();
        idle();
        chkd("col_new_data", bus.SEQ_RDATA, {16{8'h55}});

        // Stall while the buffer is full
        edge1();
        pval = rnd128();
        bus.RCEBX = 1'b0; bus.RADDRX = 16'h0030;
        bus.WCEBX = 1'b0; bus.WADDRX = 16'h0030; bus.WDATAX = pval;
        #3;
        chk1("stl_stall_t", bus.X_STALL, 1'b0);
        edge1();
        chkd("stl_old_data", bus.SEQ_RDATA, ref_mem[8'h30]);
        ref_mem[8'h30] = pval;
        bus.WCEBX = 1'b1; bus.RADDRX = 16'h0040;
        #3;
        chk1("stl_stall_t1", bus.X_STALL, 1'b1);
        chk1("stl_web_t1", bus.WEB, 1'b0);
        chka("stl_a_t1", bus.A, 16'h0030);
        edge1();
        chk1("stl_rvalid_t2", bus.SEQ_RVALID, 1'b0);
        #3;
        chk1("stl_stall_t2", bus.X_STALL, 1'b0);
        chk1("stl_web_t2", bus.WEB, 1'b1);
        chka("stl_a_t2", bus.A, 16'h0040);
        edge1();
        idle();
        chk1("stl_rvalid", bus.SEQ_RVALID, 1'b1);
        chkd("stl_rdata", bus.SEQ_RDATA, ref_mem[8'h40]);

        // Host starvation under continuous sequencer reads
        edge1();
        bus.RCEBX = 1'b0; bus.RADDRX = 16'h0050;
        bus.HOST_REQ = 1'b1; bus.HOST_WE = 1'b0; bus.HOST_ADDR = 16'h0090;
        for (int k = 0; k <= STARVE_MAX; k++) begin
            #3;
            chk1("stv_deny", bus.HOST_GNT, 1'b0);
            edge1();
        end
        #3;
        chk1("stv_gnt", bus.HOST_GNT, 1'b1);
        chk1("stv_stall", bus.X_STALL, 1'b1);
        chka("stv_a", bus.A, 16'h0090);
        edge1();
        idle();
        chk1("stv_host_rvalid", bus.HOST_RVALID, 1'b1);
        chkd("stv_host_rdata", bus.HOST_RDATA, ref_mem[8'h90]);
        chk1("stv_seq_rvalid", bus.SEQ_RVALID, 1'b0);
        chka("stv_cnt_clr", 16'(dut.u_starve.starve_cnt), 16'h0000);

        // Host read on an idle bus
        edge1();
        bus.HOST_REQ = 1'b1; bus.HOST_WE = 1'b0; bus.HOST_ADDR = 16'h0003;
        #3;
        chk1("hrd_gnt", bus.HOST_GNT, 1'b1);
        edge1();
        idle();
        chk1("hrd_rvalid", bus.HOST_RVALID, 1'b1);
        chkd("hrd_rdata", bus.HOST_RDATA, ref_mem[8'h03]);
        chk1("hrd_seq_rvalid", bus.SEQ_RVALID, 1'b0);
        #3;
        chk1("hrd_gnt_once", bus.HOST_GNT, 1'b0);

        // PURGE with the buffer valid and a waiting host
        edge1();
        bus.RCEBX = 1'b0; bus.RADDRX = 16'h0050;
        bus.HOST_REQ = 1'b1; bus.HOST_WE = 1'b0; bus.HOST_ADDR = 16'h00A0;
        for (int k = 0; k < 3; k++) edge1();
        pval = rnd128();
        bus.RADDRX = 16'h0060;
        bus.WCEBX = 1'b0; bus.WADDRX = 16'h0060; bus.WDATAX = pval;
        #3;
        chk1("prg_stall_t", bus.X_STALL, 1'b0);
        edge1();
        chkd("prg_old_data", bus.SEQ_RDATA, ref_mem[8'h60]);
        ref_mem[8'h60] = pval;
        bus.RCEBX = 1'b1; bus.WCEBX = 1'b1; bus.PURGE = 1'b1;
        #3;
        chk1("prg_web", bus.WEB, 1'b0);
        chka("prg_a", bus.A, 16'h0060);
        chkd("prg_d", bus.D, pval);
        edge1();
        bus.PURGE = 1'b0;
        chka("prg_cnt_clr", 16'(dut.u_starve.starve_cnt), 16'h0000);
        #3;
        chk1("prg_host_gnt", bus.HOST_GNT, 1'b1);
        edge1();
        idle();
        chkd("prg_host_rdata", bus.HOST_RDATA, ref_mem[8'hA0]);
        bus.RCEBX = 1'b0; bus.RADDRX = 16'h0060;
        edge1();
        idle();
        chkd("prg_new_data", bus.SEQ_RDATA, pval);

        // Asynchronous reset mid-stream drops the buffered write
        edge1();
        bus.RCEBX = 1'b0; bus.RADDRX = 16'h0070;
        bus.WCEBX = 1'b0; bus.WADDRX = 16'h0070; bus.WDATAX = rnd128();
        edge1();
        bus.WCEBX = 1'b1; bus.RADDRX = 16'h0071;
        bus.HOST_REQ = 1'b1; bus.HOST_WE = 1'b0; bus.HOST_ADDR = 16'h00B0;
        chk1("ar_pre_rvalid", bus.SEQ_RVALID, 1'b1);
        #1;
        chk1("ar_pre_ceb", bus.CEB, 1'b0);
        chk1("ar_pre_stall", bus.X_STALL, 1'b1);
        #1;
        RST = 1'b1;
        #1;
        chk1("ar_ceb", bus.CEB, 1'b1);
        chk1("ar_web", bus.WEB, 1'b1);
        chk1("ar_stall", bus.X_STALL, 1'b0);
        chk1("ar_seq_rvalid", bus.SEQ_RVALID, 1'b0);
        chk1("ar_host_rvalid", bus.HOST_RVALID, 1'b0);
        chk1("ar_host_gnt", bus.HOST_GNT, 1'b0);
        edge1();
        idle();
        RST = 1'b0;

        // Randomized traffic; host confined to the upper half so its order
        // relative to buffered write-backs never matters
        rd_p = 1'b0; wr_p = 1'b0; h_p = 1'b0; h_we = 1'b0; h_purged = 1'b0;
        rd_a = '0; wr_a = '0; h_a = '0; wr_d = '0; h_d = '0; h_wait = 0;
        e_sv = 1'b0; e_hv = 1'b0; e_sd = '0; e_hd = '0;
        for (int c = 0; c < 2000; c++) begin
            edge1();
            chk1("rnd_seq_rvalid", bus.SEQ_RVALID, e_sv);
            if (e_sv) chkd("rnd_seq_rdata", bus.SEQ_RDATA, e_sd);
            chk1("rnd_host_rvalid", bus.HOST_RVALID, e_hv);
            if (e_hv) chkd("rnd_host_rdata", bus.HOST_RDATA, e_hd);
            if (!rd_p && $urandom_range(99) < 45) begin
                rd_p = 1'b1; rd_a = 16'($urandom_range(255));
            end
            if (!wr_p && $urandom_range(99) < 35) begin
                wr_p = 1'b1; wr_a = 16'($urandom_range(127)); wr_d = rnd128();
            end
            if (!h_p && $urandom_range(99) < 12) begin
                h_p = 1'b1; h_we = ($urandom_range(1) == 1);
                h_a = 16'($urandom_range(255, 128)); h_d = rnd128();
                h_wait = 0; h_purged = 1'b0;
            end
            bus.PURGE = ($urandom_range(99) < 3);
            if (bus.PURGE) h_purged = 1'b1;
            bus.RCEBX = ~rd_p; bus.RADDRX = rd_a;
            bus.WCEBX = ~wr_p; bus.WADDRX = wr_a; bus.WDATAX = wr_d;
            bus.HOST_REQ = h_p; bus.HOST_WE = h_we; bus.HOST_ADDR = h_a; bus.HOST_WDATA = h_d;
            #3;
            stall = bus.X_STALL;
            gnt   = bus.HOST_GNT;
            if (!rd_p && !wr_p) chk1("rnd_no_stall", stall, 1'b0);
            if (!h_p) chk1("rnd_no_gnt", gnt, 1'b0);
            if (gnt && (rd_p || wr_p)) chk1("rnd_gnt_excl", stall, 1'b1);
            e_sv = rd_p && !stall;
            e_sd = ref_mem[rd_a[7:0]];
            e_hv = gnt && !h_we;
            e_hd = ref_mem[h_a[7:0]];
            if (rd_p && !stall) rd_p = 1'b0;
            if (wr_p && !stall) begin
                ref_mem[wr_a[7:0]] = wr_d;
                wr_p = 1'b0;
            end
            if (gnt) begin
                if (h_we) ref_mem[h_a[7:0]] = h_d;
                h_p = 1'b0;
            end else if (h_p) begin
                h_wait++;
                if (!h_purged) chk1("rnd_starve_bound", (h_wait <= STARVE_MAX + 1), 1'b1);
            end
        end
        edge1();
        idle();
        repeat (3) edge1();

        for (int a = 0; a < 256; a++) chkd("final_mem", mem[a], ref_mem[a]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
